arbitro_bus_memoria: RTL and testbench

ARBITRO_BUS_MEMORIA -- requirements
Module: arbitro_bus_memoria

---
 rtl/arbitro_bus_memoria.sv | 106 ++++++++++
 tb/tb_arbitro_bus_memoria.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_bus_memoria.sv
// rtl/arbitro_bus_memoria.sv - shared memory port arbiter between instruction fetch and data stage
// Data wins ties, but a fetch starved for MAX_ESPERA data grants takes the next slot.
module arbitro_bus_memoria #(
  parameter int LATENCIA   = 2,
  parameter int MAX_ESPERA = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_inst,
  input  logic [31:0] dir_inst,
  input  logic        req_dato,
  input  logic        escr_dato,
  input  logic [31:0] mem_rdata,
  output logic        sel,
  output logic        mem_en,
  output logic        mem_we,
  output logic        ack_inst,
  output logic        ack_dato,
  output logic [31:0] dato_leido,
  output logic        ocupado
);

  typedef enum logic [1:0] {
    LIBRE  = 2'd0,
    ACCESO = 2'd1,
    FIN    = 2'd2
  } estado_t;

  localparam logic [3:0] ULTIMO = 4'(LATENCIA);
  localparam logic [3:0] TOPE   = 4'(MAX_ESPERA);

  estado_t     estado;
  logic [3:0]  ciclo;
  logic [3:0]  contador_espera;
  logic        escritura;
  logic        toma_dato;
  logic        unused_dir;

  // The address itself is steered by the external mux through sel.
  assign unused_dir = ^dir_inst;

  assign toma_dato = req_dato && !(req_inst && (contador_espera == TOPE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado          <= LIBRE;
      ciclo           <= 4'd1;
      contador_espera <= 4'd0;
      escritura       <= 1'b0;
      sel             <= 1'b0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      ack_inst        <= 1'b0;
      ack_dato        <= 1'b0;
      dato_leido      <= 32'h0;
      ocupado         <= 1'b0;
    end else begin
      case (estado)
        LIBRE: begin
          if (toma_dato) begin
            estado    <= ACCESO;
            ciclo     <= 4'd1;
            ocupado   <= 1'b1;
            sel       <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= escr_dato;
            escritura <= escr_dato;
            if (req_inst && (contador_espera != TOPE))
              contador_espera <= contador_espera + 4'd1;
          end else if (req_inst) begin
            estado          <= ACCESO;
            ciclo           <= 4'd1;
            ocupado         <= 1'b1;
            sel             <= 1'b0;
            mem_en          <= 1'b1;
            mem_we          <= 1'b0;
            escritura       <= 1'b0;
            contador_espera <= 4'd0;
          end
        end
        ACCESO: begin
          if (ciclo == ULTIMO) begin
            // Write direction is latched at grant so a dropped request cannot change it.
            if (!escritura)
              dato_leido <= mem_rdata;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            ack_inst <= !sel;
            ack_dato <= sel;
            estado   <= FIN;
          end else begin
            ciclo <= ciclo + 4'd1;
          end
        end
        FIN: begin
          ack_inst <= 1'b0;
          ack_dato <= 1'b0;
          ocupado  <= 1'b0;
          estado   <= LIBRE;
        end
        default: estado <= LIBRE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_bus_memoria.sv
// tb/tb_arbitro_bus_memoria.sv - self-checking bench for arbitro_bus_memoria
module tb_arbitro_bus_memoria;

  localparam int LAT  = 2;
  localparam int MAXE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_inst = 1'b0;
  logic [31:0] dir_inst = 32'h0;
  logic        req_dato = 1'b0;
  logic        escr_dato = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        sel, mem_en, mem_we, ack_inst, ack_dato, ocupado;
  logic [31:0] dato_leido;

  int nvec = 0;
  int nerr = 0;

  arbitro_bus_memoria #(.LATENCIA(LAT), .MAX_ESPERA(MAXE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_inst(req_inst), .dir_inst(dir_inst),
    .req_dato(req_dato), .escr_dato(escr_dato),
    .mem_rdata(mem_rdata),
    .sel(sel), .mem_en(mem_en), .mem_we(mem_we),
    .ack_inst(ack_inst), .ack_dato(ack_dato),
    .dato_leido(dato_leido), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // Control outputs packed as {sel, mem_en, mem_we, ack_inst, ack_dato, ocupado}.
  function automatic logic [5:0] ctl();
    return {sel, mem_en, mem_we, ack_inst, ack_dato, ocupado};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    nvec++;
    if (ctl() !== 6'b0 || dato_leido !== 32'h0) begin
      nerr++;
      $display("FAIL reset: ctl=%b dato=%h, want ctl=000000 dato=00000000", ctl(), dato_leido);
    end
    rst_n = 1'b1;
    tick();
    nvec++;
    if (ctl() !== 6'b0 || dato_leido !== 32'h0) begin
      nerr++;
      $display("FAIL reset_release: ctl=%b dato=%h, want ctl=000000 dato=00000000", ctl(), dato_leido);
    end
  endtask

  task automatic test_read_inst();
    logic [5:0] exp;
    req_inst  = 1'b1;
    dir_inst  = 32'h0040_0000;
    mem_rdata = 32'h8C22_0004;
    for (int c = 1; c <= LAT + 2; c++) begin
      tick();
      exp = {1'b0, c <= LAT, 1'b0, c == LAT + 1, 1'b0, c <= LAT + 1};
      nvec++;
      if (ctl() !== exp) begin
        nerr++;
        $display("FAIL read_inst c%0d: ctl=%b, want %b", c, ctl(), exp);
      end
      if (c == LAT + 1) begin
        nvec++;
        if (dato_leido !== 32'h8C22_0004) begin
          nerr++;
          $display("FAIL read_inst_data: dato=%h, want 8c220004", dato_leido);
        end
        req_inst = 1'b0;
      end
    end
  endtask

  task automatic test_write_dato();
    logic [5:0] exp;
    req_dato  = 1'b1;
    escr_dato = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= LAT + 2; c++) begin
      tick();
      exp = {1'b1, c <= LAT, c <= LAT, 1'b0, c == LAT + 1, c <= LAT + 1};
      nvec++;
      if (ctl() !== exp) begin
        nerr++;
        $display("FAIL write_dato c%0d: ctl=%b, want %b", c, ctl(), exp);
      end
      if (c == LAT + 1) req_dato = 1'b0;
    end
    nvec++;
    if (dato_leido !== 32'h8C22_0004) begin
      nerr++;
      $display("FAIL write_keeps_data: dato=%h, want 8c220004", dato_leido);
    end
  endtask

  task automatic test_arbitration();
    int   grants = 0;
    logic exp_inst;
    req_inst  = 1'b1;
    req_dato  = 1'b1;
    escr_dato = 1'b0;
    for (int cyc = 0; cyc < 100 && grants < 8; cyc++) begin
      tick();
      nvec++;
      if (ack_inst && ack_dato) begin
        nerr++;
        $display("FAIL ack_exclusive: ack_inst=%b ack_dato=%b, want not both", ack_inst, ack_dato);
      end
      if (ack_inst || ack_dato) begin
        exp_inst = (grants % 4 == 3);
        nvec++;
        if (ack_inst !== exp_inst) begin
          nerr++;
          $display("FAIL grant_order #%0d: ack_inst=%b, want %b", grants, ack_inst, exp_inst);
        end
        grants++;
      end
    end
    nvec++;
    if (grants != 8) begin
      nerr++;
      $display("FAIL arbitration_timeout: grants=%0d, want 8", grants);
    end
    req_inst = 1'b0;
    req_dato = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    mem_rdata = 32'h1234_5678;
    req_dato  = 1'b1;
    escr_dato = 1'b0;
    tick();
    tick();
    rst_n    = 1'b0;
    req_dato = 1'b0;
    tick();
    nvec++;
    if (ctl() !== 6'b0 || dato_leido !== 32'h0) begin
      nerr++;
      $display("FAIL reset_mid: ctl=%b dato=%h, want ctl=000000 dato=00000000", ctl(), dato_leido);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      nvec++;
      if (ctl() !== 6'b0) begin
        nerr++;
        $display("FAIL reset_mid_no_ack c%0d: ctl=%b, want 000000", c, ctl());
      end
    end
  endtask

  task automatic test_drop();
    logic [5:0] exp;
    req_inst  = 1'b1;
    req_dato  = 1'b1;
    escr_dato = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      case (c)
        1, 2:    exp = 6'b111001;
        3:       exp = 6'b100011;
        4:       exp = 6'b100000;
        5, 6:    exp = 6'b010001;
        7:       exp = 6'b000101;
        default: exp = 6'b000000;
      endcase
      nvec++;
      if (ctl() !== exp) begin
        nerr++;
        $display("FAIL drop c%0d: ctl=%b, want %b", c, ctl(), exp);
      end
      if (c == 1) req_dato = 1'b0;
      if (c == 7) begin
        req_inst = 1'b0;
        nvec++;
        if (dato_leido !== 32'hCAFE_0001) begin
          nerr++;
          $display("FAIL drop_inst_data: dato=%h, want cafe0001", dato_leido);
        end
      end
    end
  endtask

  // Reference: a transaction occupies LAT enable cycles plus one ack cycle, then one idle cycle.
  task automatic test_random();
    int          m_left = 0;
    int          m_cnt = 0;
    logic        m_sel = 1'b0;
    logic        m_wr = 1'b0;
    logic [31:0] m_dato = 32'h0;
    logic        ri, rd, we;
    logic [31:0] rdat;
    logic [5:0]  exp;
    rst_n    = 1'b0;
    req_inst = 1'b0;
    req_dato = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      ri = req_inst;
      rd = req_dato;
      we = escr_dato;
      rdat = mem_rdata;
      tick();
      if (m_left == 0) begin
        if (rd && !(ri && m_cnt == MAXE)) begin
          m_sel = 1'b1;
          m_wr = we;
          m_left = LAT + 1;
          if (ri && m_cnt < MAXE) m_cnt++;
        end else if (ri) begin
          m_sel = 1'b0;
          m_wr = 1'b0;
          m_left = LAT + 1;
          m_cnt = 0;
        end
      end else begin
        if (m_left == 2 && !m_wr) m_dato = rdat;
        m_left--;
      end
      exp = {m_sel, m_left > 1, (m_left > 1) && m_sel && m_wr,
             (m_left == 1) && !m_sel, (m_left == 1) && m_sel, m_left > 0};
      nvec++;
      if (ctl() !== exp || dato_leido !== m_dato) begin
        nerr++;
        $display("FAIL random n%0d: ctl=%b dato=%h, want ctl=%b dato=%h", n, ctl(), dato_leido, exp, m_dato);
      end
      mem_rdata = $urandom;
      if (ack_inst) req_inst = 1'b0;
      else if (!req_inst && $urandom_range(0, 2) == 0) begin
        req_inst = 1'b1;
        dir_inst = $urandom;
      end
      if (ack_dato) req_dato = 1'b0;
      else if (!req_dato && $urandom_range(0, 2) == 0) begin
        req_dato  = 1'b1;
        escr_dato = 1'($urandom_range(0, 1));
      end
    end
    req_inst = 1'b0;
    req_dato = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_inst();
    test_write_dato();
    test_arbitration();
    test_reset_mid();
    test_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, want completion");
    $fatal(1);
  end

endmodule
